// File: rtl/stage_pkg.sv
// Shared definitions for the stage-controller / spotlight interface.
// Holds the one-hot spo command codes and the spotlight driver state type.
package stage_pkg;

  // spo command codes: [2]=Left, [1]=Centre, [0]=Right, all-zero = off/park
  localparam logic [2:0] SPO_OFF = 3'b000;
  localparam logic [2:0] SPO_L   = 3'b100;
  localparam logic [2:0] SPO_C   = 3'b010;
  localparam logic [2:0] SPO_R   = 3'b001;

  typedef enum logic [1:0] {
    SD_IDLE,
    SD_MOVE,
    SD_SETTLE
  } sd_state_t;

endpackage

// File: rtl/step_rate_div.sv
// Free-running modulo-MAX counter with synchronous clear.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - forces the count to 0 on the next edge (wins over en)
//   en         - advance the count; wraps from MAX-1 to 0
//   tc         - terminal count, high while the count equals MAX-1
module step_rate_div #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(MAX - 1));

endmodule

// File: rtl/spotlight_driver.sv
// Spotlight head driver: turns the one-hot spo command into stepper
// step/dir pulses, tracks the head position and drives the lamp enable.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (reset re-homes to centre)
//   spo        - command: [2]=Left, [1]=Centre, [0]=Right, 000=off (park)
//   step       - one-cycle step pulse
//   dir        - 1 = increasing position (toward Right)
//   motor_en   - motor driver enable (MOVE and SETTLE)
//   pos        - current head position in steps
//   at_target  - idle with pos equal to the commanded target
//   lamp_on    - lamp enable from the registered command
//   fault      - sticky flag for an illegal spo code
module spotlight_driver
  import stage_pkg::*;
#(
  parameter int unsigned POS_W      = 8,
  parameter int unsigned POS_LEFT   = 16,
  parameter int unsigned POS_CENTER = 64,
  parameter int unsigned POS_RIGHT  = 112,
  parameter int unsigned STEP_DIV   = 4,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       spo,
  output logic             step,
  output logic             dir,
  output logic             motor_en,
  output logic [POS_W-1:0] pos,
  output logic             at_target,
  output logic             lamp_on,
  output logic             fault
);

  logic [2:0]       spo_q;
  logic [POS_W-1:0] target_q;
  logic             lamp_q;

  logic             dec_valid;
  logic [POS_W-1:0] dec_target;
  logic             dec_lamp;

  sd_state_t        state_q, state_d;
  logic             div_tc, set_tc;
  logic [POS_W-1:0] pos_step, pos_next;
  logic             dir_load;

  // Command decode; an illegal code keeps the last legal target and lamp.
  always_comb begin
    dec_valid  = 1'b1;
    dec_target = target_q;
    dec_lamp   = lamp_q;
    case (spo_q)
      SPO_L:   begin dec_target = POS_W'(POS_LEFT);   dec_lamp = 1'b1; end
      SPO_C:   begin dec_target = POS_W'(POS_CENTER); dec_lamp = 1'b1; end
      SPO_R:   begin dec_target = POS_W'(POS_RIGHT);  dec_lamp = 1'b1; end
      SPO_OFF: begin dec_target = POS_W'(POS_CENTER); dec_lamp = 1'b0; end
      default: dec_valid = 1'b0;
    endcase
  end

  assign lamp_on = dec_lamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spo_q    <= SPO_OFF;
      target_q <= POS_W'(POS_CENTER);
      lamp_q   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      spo_q    <= spo;
      target_q <= dec_target;
      lamp_q   <= dec_lamp;
      fault    <= fault | ~dec_valid;
    end
  end

  // Step period divider runs only in MOVE and restarts at 0 on every entry.
  step_rate_div #(.MAX(STEP_DIV)) u_step_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != SD_MOVE),
    .en    (state_q == SD_MOVE),
    .tc    (div_tc)
  );

  step_rate_div #(.MAX(SETTLE_CYC)) u_settle_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != SD_SETTLE),
    .en    (state_q == SD_SETTLE),
    .tc    (set_tc)
  );

  // Saturating one-step move in the current direction.
  always_comb begin
    pos_step = pos;
    if (dir) begin
      if (pos != '1) pos_step = pos + 1'b1;
    end else begin
      if (pos != '0) pos_step = pos - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    step     = 1'b0;
    motor_en = 1'b0;
    case (state_q)
      SD_IDLE: begin
        if (target_q != pos) state_d = SD_MOVE;
      end
      SD_MOVE: begin
        motor_en = 1'b1;
        if (div_tc) begin
          step = 1'b1;
          if (pos_step == target_q) state_d = SD_SETTLE;
        end
      end
      SD_SETTLE: begin
        motor_en = 1'b1;
        if (target_q != pos) state_d = SD_MOVE;
        else if (set_tc)     state_d = SD_IDLE;
      end
      default: state_d = SD_IDLE;
    endcase
  end

  // dir is loaded on the edge that starts divider count 0 (MOVE entry or a
  // step that continues moving), so it is stable for STEP_DIV-1 cycles
  // before the step and a retarget only bites at the next period.
  assign pos_next = step ? pos_step : pos;
  assign dir_load = (state_d == SD_MOVE) && ((state_q != SD_MOVE) || step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= POS_W'(POS_CENTER);
      dir <= 1'b0;
    end else begin
      pos <= pos_next;
      if (dir_load) dir <= (target_q > pos_next);
    end
  end

  assign at_target = (state_q == SD_IDLE) && (pos == target_q);

endmodule

// File: doc/spotlight_driver.md
# spotlight_driver

Receiving end of the spotlight position interface. Consumes the 3-bit one-hot spotlight command `spo` produced by the stage controller and turns it into stepper-motor step/direction pulses, a tracked head position and a lamp enable. It sits between the `main` controller output and the physical spotlight head. A parked position at centre is the mechanical home.

## Interface
- `POS_W`, 8 — width of the position counter
- `POS_LEFT`, 16 — step position for Left
- `POS_CENTER`, 64 — step position for Centre; also the reset/home position
- `POS_RIGHT`, 112 — step position for Right
- `STEP_DIV`, 4 — clocks per step, ≥2
- `SETTLE_CYC`, 3 — hold cycles after arrival before `at_target`, ≥1

Ports:
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `spo` in 3 — command: [2]=Left, [1]=Centre, [0]=Right, 000=off
- `step` out 1 — one-cycle step pulse
- `dir` out 1 — 1 = increasing position, toward Right
- `motor_en` out 1 — motor driver enable
- `pos` out POS_W — current head position in steps
- `at_target` out 1 — head settled at the commanded position
- `lamp_on` out 1 — spotlight lamp enable
- `fault` out 1 — sticky flag for an illegal `spo` code; cleared only by reset

## Operation
- `spo` is registered once into `spo_q`. All decode works from `spo_q`.
- Decode of `spo_q`:
  - 100 → target = `POS_LEFT`, lamp_on = 1
  - 010 → target = `POS_CENTER`, lamp_on = 1
  - 001 → target = `POS_RIGHT`, lamp_on = 1
  - 000 → target = `POS_CENTER` (park), lamp_on = 0
  - any other code → target and lamp_on hold their previous values, and `fault` sets
- State `IDLE`:
  - motor_en = 0, step = 0
  - Go to `MOVE` when target ≠ pos.
- State `MOVE`:
  - motor_en = 1
  - The divider counts 0..STEP_DIV-1.
  - At count 0, `dir` is loaded with (target > pos).
  - At count STEP_DIV-1, `step` = 1 for one cycle and pos moves ±1 per `dir`.
  - `dir` never changes in a cycle where `step` = 1 (set-up ≥ STEP_DIV-1 cycles).
  - A step that lands pos on target goes to `SETTLE`.
- State `SETTLE`:
  - motor_en = 1, step = 0
  - Counts SETTLE_CYC cycles, then goes to `IDLE`.
  - If target changes during `SETTLE` and target ≠ pos, go back to `MOVE` with the divider reset to 0.
- Retarget during `MOVE`: the new target takes effect at the next divider count 0. The in-flight step completes.
- `at_target` = 1 only in `IDLE` with pos == target.
- pos saturates at 0 and 2^POS_W−1. No wrap.

## Timing
- Reset values:
  - step = 0, dir = 0, motor_en = 0
  - pos = `POS_CENTER`, target = `POS_CENTER`
  - at_target = 1, lamp_on = 0, fault = 0, state `IDLE`
- Latency, counting the edge that samples the new `spo` as edge 0:
  - target updates at edge 1.
  - `MOVE` is entered at edge 2.
  - The first `step` is high in the cycle after edge 2+STEP_DIV−1.
- Travel time is |Δpos|·STEP_DIV cycles, plus SETTLE_CYC cycles, plus 1 cycle to `IDLE`.
- `lamp_on` follows `spo_q` decode combinationally. It changes 1 cycle after `spo`.
- Reset mid-move: every output goes to its reset value immediately. pos returns to `POS_CENTER`, because reset means the head has been re-homed.

## Structure
- Shared package `stage_pkg` holds:
  - localparams for the `spo` codes `SPO_OFF`, `SPO_L`, `SPO_C`, `SPO_R`
  - the state enum `sd_state_t {SD_IDLE, SD_MOVE, SD_SETTLE}`
- Sub-module `step_rate_div`:
  - parameterised counter with `clear` and `tc` outputs
  - used for the step divider and reused for the settle counter
- Top level `spotlight_driver` holds the decode, target register, FSM and position counter.

## Test plan
- Reset, then `spo` = 000 held → pos = 64, at_target = 1, lamp_on = 0, no `step` pulses.
- `spo` = 100 → dir = 0, exactly 48 step pulses spaced 4 cycles apart, pos = 16, then at_target = 1 after 3 settle cycles + 1; lamp_on = 1.
- From Left, `spo` = 001 → 96 pulses with dir = 1, pos = 112. Then `spo` = 000 → 48 pulses back to pos = 64 with lamp_on = 0.
- Retarget mid-move: Centre→Right. After 10 steps (pos = 74) switch to `spo` = 100 → dir flips only at the next divider count 0, with no `step` in the flip cycle. Then 58 pulses to pos = 16.
- Illegal `spo` = 110 during `IDLE` at Right → fault = 1 and stays 1, target and pos stay 112, lamp_on unchanged. A following `spo` = 010 still moves the head to 64.
- Assert `rst_n` low mid-move at pos = 90 → immediately step = 0, motor_en = 0, pos = 64, fault = 0, at_target = 1.
